// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - RV32 opcode constants, NOP encoding and predecode types
//
// Purpose: constants shared by the prefetch queue and its predecoder.
// Contents:
//   OPC_*       7-bit major opcodes, taken from instruction bits [6:0]
//   NOP_INSTR   canonical NOP (addi x0, x0, 0); this is what a bubble emits
//   predecode_t ALUSrc / RegWrite pair produced for one instruction
package rv32_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [15:0] BUBBLE_CNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic alu_src;
    logic reg_write;
  } predecode_t;

  // Decode of the NOP itself: addi reads an immediate and writes x0,
  // so RegWrite is 0 while ALUSrc is 1.
  localparam predecode_t NOP_PREDECODE = '{alu_src: 1'b1, reg_write: 1'b0};

endpackage

// File: rtl/instr_prefetch_queue_if.sv
// rtl/instr_prefetch_queue_if.sv - fetch-to-queue valid/ready instruction channel
//
// Purpose: carries fetched instructions into the prefetch queue.
// Signals:
//   in_instr  fetched instruction word
//   in_valid  in_instr is valid this cycle
//   in_ready  queue accepts this cycle; a transfer happens when both are 1
// Modports:
//   master  fetch unit side (drives in_instr / in_valid)
//   slave   queue side (drives in_ready)
interface instr_prefetch_queue_if #(
  parameter int Instr_word_size = 32
);

  logic [Instr_word_size-1:0] in_instr;
  logic                       in_valid;
  logic                       in_ready;

  modport master (
    output in_instr,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_instr,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/rv32_predecode.sv
// rtl/rv32_predecode.sv - combinational ALUSrc / RegWrite predecode of one instruction
//
// Purpose: classifies an RV32 instruction by its major opcode.
// Ports:
//   instr     instruction word (only bits [11:0] matter)
//   ALUSrc    1 when the second ALU operand is an immediate
//   RegWrite  1 when the instruction writes a nonzero rd
module rv32_predecode
  import rv32_pkg::*;
#(
  parameter int Instr_word_size = 32
) (
  input  logic [Instr_word_size-1:0] instr,
  output logic                       ALUSrc,
  output logic                       RegWrite
);

  logic [6:0] opcode;
  logic [4:0] rd;
  logic       writes_rd;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];

  // Fields above rd carry no information for this decode.
  logic unused_upper;
  assign unused_upper = ^instr[Instr_word_size-1:12];

  always_comb begin
    ALUSrc    = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      OPC_OP:     begin ALUSrc = 1'b0; writes_rd = 1'b1; end
      OPC_OP_IMM: begin ALUSrc = 1'b1; writes_rd = 1'b1; end
      OPC_LOAD:   begin ALUSrc = 1'b1; writes_rd = 1'b1; end
      OPC_STORE:  begin ALUSrc = 1'b1; writes_rd = 1'b0; end
      OPC_LUI:    begin ALUSrc = 1'b1; writes_rd = 1'b1; end
      OPC_AUIPC:  begin ALUSrc = 1'b1; writes_rd = 1'b1; end
      OPC_JAL:    begin ALUSrc = 1'b0; writes_rd = 1'b1; end
      OPC_JALR:   begin ALUSrc = 1'b1; writes_rd = 1'b1; end
      OPC_BRANCH: begin ALUSrc = 1'b0; writes_rd = 1'b0; end
      default:    begin ALUSrc = 1'b0; writes_rd = 1'b0; end
    endcase
  end

  // A write to x0 is architecturally discarded, so do not advertise it.
  assign RegWrite = writes_rd && (rd != 5'd0);

endmodule

// File: rtl/instr_prefetch_queue.sv
// rtl/instr_prefetch_queue.sv - instruction prefetch FIFO with registered predecoded output
//
// Purpose: buffers fetched instructions and presents one per cycle to the
// scheduler, inserting a NOP bubble whenever the queue runs dry.
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   fetch        valid/ready instruction input channel (slave side)
//   stall        hold outputs and bubble_cnt, no pop (pushes still allowed)
//   flush        empty the queue and emit a bubble; wins over push/pop/stall
//   Instr_out    registered instruction for the scheduler's Instr_in
//   ALUSrc       registered predecode of Instr_out
//   RegWrite     registered predecode of Instr_out
//   out_bubble   Instr_out is an inserted NOP
//   bubble_cnt   number of bubbles emitted, saturating at 0xFFFF
// depth must be a power of two and at least 2 so the pointers wrap naturally.
module instr_prefetch_queue
  import rv32_pkg::*;
#(
  parameter int Instr_word_size = 32,
  parameter int depth           = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  instr_prefetch_queue_if.slave      fetch,
  input  logic                       stall,
  input  logic                       flush,
  output logic [Instr_word_size-1:0] Instr_out,
  output logic                       ALUSrc,
  output logic                       RegWrite,
  output logic                       out_bubble,
  output logic [15:0]                bubble_cnt
);

  localparam int PW = $clog2(depth);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(depth);
  localparam logic [Instr_word_size-1:0] NOP_WORD = Instr_word_size'(NOP_INSTR);

  logic [Instr_word_size-1:0] mem [depth];
  logic [PW-1:0]              rptr;
  logic [PW-1:0]              wptr;
  logic [CW-1:0]              count;

  logic                       push;
  logic                       pop;
  logic                       empty;
  logic                       load_bubble;
  logic [Instr_word_size-1:0] head;
  predecode_t                 head_pd;

  assign empty = (count == '0);
  assign head  = mem[rptr];

  // Flush gates in_ready so a flushed cycle never reports a transfer.
  assign fetch.in_ready = (count < DEPTH_C) && !flush;
  assign push           = fetch.in_valid && fetch.in_ready;
  assign pop            = !stall && !empty && !flush;
  assign load_bubble    = flush || (!stall && empty);

  // Predecode the head entry so the result can be registered alongside it.
  rv32_predecode #(
    .Instr_word_size (Instr_word_size)
  ) u_predecode (
    .instr    (head),
    .ALUSrc   (head_pd.alu_src),
    .RegWrite (head_pd.reg_write)
  );

  // Storage holds no reset; stale entries are unreachable once count is 0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= fetch.in_instr;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Output stage: either the popped head or a NOP bubble; stall holds all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Instr_out  <= NOP_WORD;
      ALUSrc     <= NOP_PREDECODE.alu_src;
      RegWrite   <= NOP_PREDECODE.reg_write;
      out_bubble <= 1'b1;
      bubble_cnt <= '0;
    end else if (load_bubble) begin
      Instr_out  <= NOP_WORD;
      ALUSrc     <= NOP_PREDECODE.alu_src;
      RegWrite   <= NOP_PREDECODE.reg_write;
      out_bubble <= 1'b1;
      if (bubble_cnt != BUBBLE_CNT_MAX) begin
        bubble_cnt <= bubble_cnt + 16'd1;
      end
    end else if (pop) begin
      Instr_out  <= head;
      ALUSrc     <= head_pd.alu_src;
      RegWrite   <= head_pd.reg_write;
      out_bubble <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb/tb_instr_prefetch_queue.sv - directed self-checking bench for instr_prefetch_queue
module tb_instr_prefetch_queue;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] instr_out;
  logic        alu_src;
  logic        reg_write;
  logic        out_bubble;
  logic [15:0] bubble_cnt;

  int tests;
  int fails;

  logic [31:0] q8 [8];

  instr_prefetch_queue_if #(.Instr_word_size(32)) bus ();

  instr_prefetch_queue #(
    .Instr_word_size (32),
    .depth           (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch      (bus),
    .stall      (stall),
    .flush      (flush),
    .Instr_out  (instr_out),
    .ALUSrc     (alu_src),
    .RegWrite   (reg_write),
    .out_bubble (out_bubble),
    .bubble_cnt (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_instr = 32'h0;
    for (int i = 0; i < 8; i++) begin
      q8[i] = {12'(i + 1), 5'd0, 3'd0, 5'(i + 1), 7'h13};
    end

    // Reset state
    step();
    step();
    chk("rst_instr", instr_out, 32'h00000013);
    chk("rst_alusrc", {31'd0, alu_src}, 32'd1);
    chk("rst_regwrite", {31'd0, reg_write}, 32'd0);
    chk("rst_bubble", {31'd0, out_bubble}, 32'd1);
    chk("rst_cnt", {16'd0, bubble_cnt}, 32'd0);
    chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);
    rst = 1'b0;

    // Idle 5 cycles
    for (int i = 0; i < 5; i++) step();
    chk("idle_instr", instr_out, 32'h00000013);
    chk("idle_bubble", {31'd0, out_bubble}, 32'd1);
    chk("idle_cnt", {16'd0, bubble_cnt}, 32'd5);

    // addi then add, one edge latency
    bus.in_instr = 32'h00500093; bus.in_valid = 1'b1;
    step();
    bus.in_instr = 32'h00208133;
    step();
    chk("addi_instr", instr_out, 32'h00500093);
    chk("addi_alusrc", {31'd0, alu_src}, 32'd1);
    chk("addi_regwrite", {31'd0, reg_write}, 32'd1);
    chk("addi_bubble", {31'd0, out_bubble}, 32'd0);
    bus.in_valid = 1'b0;
    step();
    chk("add_instr", instr_out, 32'h00208133);
    chk("add_alusrc", {31'd0, alu_src}, 32'd0);
    chk("add_regwrite", {31'd0, reg_write}, 32'd1);
    chk("add_bubble", {31'd0, out_bubble}, 32'd0);
    step();
    chk("after_add_bubble", {31'd0, out_bubble}, 32'd1);
    chk("after_add_cnt", {16'd0, bubble_cnt}, 32'd7);

    // Fill under stall, then drain
    stall = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_instr = q8[i]; bus.in_valid = 1'b1;
      #1;
      chk($sformatf("fill_ready_%0d", i), {31'd0, bus.in_ready}, 32'd1);
      step();
    end
    bus.in_instr = 32'h00C00613;
    #1;
    chk("full_ready", {31'd0, bus.in_ready}, 32'd0);
    step();
    chk("stall_hold_cnt", {16'd0, bubble_cnt}, 32'd7);
    chk("stall_hold_bubble", {31'd0, out_bubble}, 32'd1);
    chk("stall_hold_instr", instr_out, 32'h00000013);
    stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      bus.in_valid = 1'b0;
      chk($sformatf("drain_instr_%0d", i), instr_out, q8[i]);
      chk($sformatf("drain_bubble_%0d", i), {31'd0, out_bubble}, 32'd0);
    end
    step();
    chk("drain_end_instr", instr_out, 32'h00000013);
    chk("drain_end_cnt", {16'd0, bubble_cnt}, 32'd8);

    // sw then beq
    bus.in_instr = 32'h0020A023; bus.in_valid = 1'b1;
    step();
    bus.in_instr = 32'h00000063;
    step();
    bus.in_valid = 1'b0;
    chk("sw_instr", instr_out, 32'h0020A023);
    chk("sw_alusrc", {31'd0, alu_src}, 32'd1);
    chk("sw_regwrite", {31'd0, reg_write}, 32'd0);
    step();
    chk("beq_instr", instr_out, 32'h00000063);
    chk("beq_alusrc", {31'd0, alu_src}, 32'd0);
    chk("beq_regwrite", {31'd0, reg_write}, 32'd0);
    step();
    chk("after_beq_cnt", {16'd0, bubble_cnt}, 32'd10);

    // Flush with 3 queued, stall held, in_valid presenting
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_instr = q8[i]; bus.in_valid = 1'b1;
      step();
    end
    flush = 1'b1;
    bus.in_instr = 32'h00D00693;
    #1;
    chk("flush_ready", {31'd0, bus.in_ready}, 32'd0);
    step();
    chk("flush_instr", instr_out, 32'h00000013);
    chk("flush_bubble", {31'd0, out_bubble}, 32'd1);
    chk("flush_cnt", {16'd0, bubble_cnt}, 32'd11);
    flush = 1'b0; stall = 1'b0; bus.in_valid = 1'b0;
    step();
    chk("post_flush_bubble", {31'd0, out_bubble}, 32'd1);
    chk("post_flush_instr", instr_out, 32'h00000013);
    chk("post_flush_cnt", {16'd0, bubble_cnt}, 32'd12);
    chk("post_flush_ready", {31'd0, bus.in_ready}, 32'd1);

    // Asynchronous reset mid-operation
    bus.in_instr = q8[0]; bus.in_valid = 1'b1;
    step();
    bus.in_instr = q8[1];
    step();
    bus.in_instr = q8[2];
    step();
    bus.in_valid = 1'b0; stall = 1'b1;
    chk("pre_rst_instr", instr_out, q8[1]);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_instr", instr_out, 32'h00000013);
    chk("async_rst_alusrc", {31'd0, alu_src}, 32'd1);
    chk("async_rst_bubble", {31'd0, out_bubble}, 32'd1);
    chk("async_rst_cnt", {16'd0, bubble_cnt}, 32'd0);
    step();
    rst = 1'b0; stall = 1'b0;
    #1;
    chk("rel_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    chk("rel_bubble", {31'd0, out_bubble}, 32'd1);
    chk("rel_cnt", {16'd0, bubble_cnt}, 32'd1);

    // Saturation of bubble_cnt
    for (int i = 0; i < 65533; i++) step();
    chk("sat_fffe", {16'd0, bubble_cnt}, 32'h0000FFFE);
    for (int i = 0; i < 3; i++) step();
    chk("sat_ffff", {16'd0, bubble_cnt}, 32'h0000FFFF);
    chk("sat_instr", instr_out, 32'h00000013);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_queue.md
INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

Interface
REQ-001 SHALL have parameter Instr_word_size, default 32, instruction width in bits.
REQ-002 SHALL have parameter depth, default 8, queue entries; a power of two and at least 2.
REQ-003 SHALL have clk, input, 1: the single clock; all state changes on the rising edge.
REQ-004 SHALL have rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have in_instr, input, Instr_word_size: fetched instruction.
REQ-006 SHALL have in_valid, input, 1: in_instr is valid this cycle.
REQ-007 SHALL have in_ready, output, 1: the queue accepts this cycle; combinational, equals (count < depth) AND NOT flush.
REQ-008 SHALL have stall, input, 1: hold the output and do not pop.
REQ-009 SHALL have flush, input, 1: discard all queued instructions.
REQ-010 SHALL have Instr_out, output, Instr_word_size: registered instruction driven to the downstream scheduler's Instr_in.
REQ-011 SHALL have ALUSrc and RegWrite, outputs, 1 each: registered predecode of Instr_out.
REQ-012 SHALL have out_bubble, output, 1: registered; Instr_out is an inserted NOP.
REQ-013 SHALL have bubble_cnt, output, 16: bubbles emitted, saturating.

Function
REQ-014 SHALL accept (push) in_instr at the edge where in_valid AND in_ready are both 1.
REQ-015 SHALL NOT push when full, even if a pop occurs in the same cycle.
REQ-016 SHALL, at each edge with stall=0 and count>0, load the head entry into the output registers, pop it, and clear out_bubble.
REQ-017 SHALL, at each edge with stall=0 and count=0, load NOP 0x00000013 with ALUSrc=1, RegWrite=0, out_bubble=1, and increment bubble_cnt, saturating at 0xFFFF.
REQ-018 SHALL, at an edge with stall=1, hold all output registers and bubble_cnt, with no pop; a push remains allowed.
REQ-019 SHALL give latency of exactly one edge: an instruction pushed at edge N into an empty queue appears on Instr_out after edge N+1, provided stall=0.
REQ-020 SHALL preserve FIFO order and SHALL wrap the read and write pointers modulo depth.
REQ-021 SHALL keep count at width clog2(depth)+1 with count = pushes minus pops.
REQ-022 SHALL perform simultaneous push and pop with count unchanged.
REQ-023 SHALL, at an edge with flush=1, zero count and both pointers and load a bubble (per REQ-017) regardless of stall.
REQ-024 SHALL give flush priority over push and pop; any instruction presented in that cycle is dropped.
REQ-025 SHALL predecode from opcode bits [6:0]:
  - RegWrite=1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR; 0 otherwise.
  - RegWrite forced to 0 when rd ([11:7]) is 0.
  - ALUSrc=1 for OP-IMM, LOAD, STORE, LUI, AUIPC, JALR; 0 otherwise.
  - Unknown opcodes pass through with ALUSrc=0, RegWrite=0.

Reset
REQ-026 SHALL, while rst=1, asynchronously set count, pointers and bubble_cnt to 0 and set Instr_out=0x00000013, ALUSrc=1, RegWrite=0, out_bubble=1.
REQ-027 SHALL let rst asserted mid-operation discard queue contents immediately; in_ready SHALL be 1 after release.
REQ-028 SHALL NOT reset queue storage contents.

Structure
REQ-029 SHALL place the opcode constants and the NOP constant in a shared package, rv32_pkg.
REQ-030 SHALL implement predecode as one combinational sub-module, rv32_predecode, with inputs instr and outputs ALUSrc and RegWrite.

Verification
REQ-031 SHALL cover reset then idle for 5 cycles -> Instr_out=0x00000013, out_bubble=1, bubble_cnt=5.
REQ-032 SHALL cover pushing 0x00500093 (addi x1,x0,5) then 0x00208133 (add x2,x1,x2) -> outputs appear in order one edge after each push; ALUSrc/RegWrite = 1/1 then 0/1.
REQ-033 SHALL cover holding stall=1 while pushing 8 instructions (depth=8) -> in_ready=0 on the 9th; deasserting stall drains all 8 in order with no bubble between them.
REQ-034 SHALL cover pushing 0x0020A023 (sw) and 0x00000063 (beq x0,x0) -> RegWrite=0 for both; ALUSrc=1 then 0.
REQ-035 SHALL cover flush with 3 entries queued and in_valid=1 -> the next output is a bubble, count=0, and the presented instruction never appears.
REQ-036 SHALL cover forcing bubble_cnt to 0xFFFE and idling 3 cycles -> bubble_cnt=0xFFFF and holds.
